// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period (rise to rise) and high time of a slow signal in sclk cycles
module clk_period_meter #(
  parameter int CNT_W = 16,
  parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(50000),
  parameter bit SYNC_EN = 1'b1
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             pi_sig,
  input  logic             pi_en,
  output logic [CNT_W-1:0] po_period,
  output logic [CNT_W-1:0] po_high,
  output logic             po_valid,
  output logic             po_timeout,
  output logic             po_stable
);
  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
  state_t r_state, w_state_nxt;
  logic w_s, r_sd, w_rise, w_at_to;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, r_hcnt, w_hcnt_nxt, w_period_nxt, w_high_nxt;
  logic w_valid_nxt, w_timeout_nxt, w_stable_nxt;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  if (SYNC_EN) begin : g_sync
    logic [1:0] r_sync;
    // two-flop synchroniser bringing the asynchronous input into sclk
    always_ff @(posedge sclk) r_sync <= rst ? 2'b00 : {r_sync[0], pi_sig};
    assign w_s = r_sync[1];
  end else begin : g_direct
    assign w_s = pi_sig;
  end
  // one-cycle delayed copy of the input for rising-edge detection
  always_ff @(posedge sclk) r_sd <= rst ? 1'b0 : w_s;
  assign w_rise  = w_s & ~r_sd;
  assign w_at_to = r_cnt == TIMEOUT;
  // next-state and next-output logic; disable overrides everything, a rise beats the timeout
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hcnt_nxt    = r_hcnt;
    w_period_nxt  = po_period;
    w_high_nxt    = po_high;
    w_valid_nxt   = 1'b0;
    w_timeout_nxt = 1'b0;
    w_stable_nxt  = po_stable;
    if (!pi_en) begin
      w_state_nxt  = IDLE;
      w_cnt_nxt    = '0;
      w_hcnt_nxt   = '0;
      w_stable_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = ARM;
          w_cnt_nxt   = ONE;
        end
        ARM: begin
          w_state_nxt   = w_rise ? MEAS : ARM;
          w_hcnt_nxt    = w_rise ? ONE : r_hcnt;
          w_cnt_nxt     = (w_rise || w_at_to) ? ONE : r_cnt + ONE;
          w_timeout_nxt = !w_rise && w_at_to;
        end
        MEAS: begin
          if (w_rise) begin
            w_period_nxt = r_cnt;
            w_high_nxt   = r_hcnt;
            w_valid_nxt  = 1'b1;
            w_stable_nxt = r_cnt == po_period;
            w_cnt_nxt    = ONE;
            w_hcnt_nxt   = ONE;
          end else if (w_at_to) begin
            w_timeout_nxt = 1'b1;
            w_stable_nxt  = 1'b0;
            w_state_nxt   = ARM;
            w_cnt_nxt     = ONE;
          end else begin
            w_cnt_nxt  = r_cnt + ONE;
            w_hcnt_nxt = r_hcnt + CNT_W'(w_s);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end
  // state, counters and registered outputs
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_hcnt     <= '0;
      po_period  <= '0;
      po_high    <= '0;
      po_valid   <= 1'b0;
      po_timeout <= 1'b0;
      po_stable  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_hcnt     <= w_hcnt_nxt;
      po_period  <= w_period_nxt;
      po_high    <= w_high_nxt;
      po_valid   <= w_valid_nxt;
      po_timeout <= w_timeout_nxt;
      po_stable  <= w_stable_nxt;
    end
  end
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed table-driven bench for clk_period_meter with TIMEOUT=100
module tb_clk_period_meter;
  localparam int W = 16;
  logic sclk = 1'b0, rst = 1'b1, pi_sig = 1'b0, pi_en = 1'b0;
  logic [W-1:0] po_period, po_high;
  logic po_valid, po_timeout, po_stable;
  clk_period_meter #(.CNT_W(W), .TIMEOUT(16'd100), .SYNC_EN(1'b1)) dut (
    .sclk(sclk), .rst(rst), .pi_sig(pi_sig), .pi_en(pi_en),
    .po_period(po_period), .po_high(po_high), .po_valid(po_valid),
    .po_timeout(po_timeout), .po_stable(po_stable)
  );
  always #5 sclk = ~sclk;
  typedef struct { int p; int h; int reps; bit first_stable; } seg_t;
  typedef struct { int p; int h; bit st; } exp_t;
  seg_t segs[4];
  exp_t exp_q[$];
  int to_q[$];
  int n_vec = 0, n_fail = 0, cyc = 0, n_valid = 0, n_to = 0, last_vcyc = -1;
  int nv0, to0, rc;
  bit chk_int = 1'b0;
  task automatic chk(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask
  task automatic step(input logic s);
    exp_t e;
    pi_sig = s;
    @(posedge sclk);
    #1;
    cyc++;
    if (po_timeout) begin
      n_to++;
      to_q.push_back(cyc);
      chk("valid_with_timeout", po_valid, 0);
    end
    if (po_valid) begin
      n_valid++;
      if (exp_q.size() == 0) chk("unexpected_valid", po_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("period", po_period, e.p);
        chk("high", po_high, e.h);
        chk("stable", po_stable, e.st);
        if (chk_int && last_vcyc >= 0) chk("valid_interval", cyc - last_vcyc, e.p);
      end
      last_vcyc = cyc;
    end
  endtask
  initial begin
    segs = '{'{4, 2, 6, 1'b0}, '{10, 3, 5, 1'b0}, '{20, 15, 3, 1'b0}, '{100, 1, 2, 1'b0}};
    step(0);
    step(0);
    chk("rst_period", po_period, 0);
    chk("rst_high", po_high, 0);
    chk("rst_valid", po_valid, 0);
    chk("rst_timeout", po_timeout, 0);
    chk("rst_stable", po_stable, 0);
    rst = 1'b0;
    pi_en = 1'b1;
    repeat (4) step(0);
    foreach (segs[i])
      for (int r = 0; r < segs[i].reps; r++)
        exp_q.push_back('{segs[i].p, segs[i].h, (r == 0) ? segs[i].first_stable : 1'b1});
    chk_int = 1'b1;
    foreach (segs[i])
      for (int r = 0; r < segs[i].reps; r++)
        for (int k = 0; k < segs[i].p; k++) step(k < segs[i].h);
    step(1);
    repeat (3) step(0);
    chk("table_valids", n_valid, 16);
    chk("table_timeouts", n_to, 0);
    chk("table_exp_left", exp_q.size(), 0);
    chk_int = 1'b0;
    to_q.delete();
    for (int i = 0; i < 250; i++) begin
      step(0);
      if (po_timeout && to_q.size() == 1) begin
        chk("to_period_held", po_period, 100);
        chk("to_high_held", po_high, 1);
        chk("to_stable", po_stable, 0);
      end
    end
    chk("to_count", to_q.size(), 2);
    if (to_q.size() >= 2) begin
      chk("to_first_delay", to_q[0] - last_vcyc, 100);
      chk("to_repeat", to_q[1] - to_q[0], 100);
    end
    rst = 1'b1;
    step(0);
    rst = 1'b0;
    repeat (3) step(0);
    nv0 = n_valid;
    exp_q.push_back('{50, 10, 1'b0});
    exp_q.push_back('{50, 10, 1'b1});
    repeat (2) begin
      repeat (10) step(1);
      repeat (40) step(0);
    end
    repeat (5) step(1);
    chk("en_pre_valids", n_valid - nv0, 2);
    pi_en = 1'b0;
    nv0 = n_valid;
    to0 = n_to;
    repeat (5) step(1);
    repeat (40) step(0);
    repeat (2) begin
      repeat (10) step(1);
      repeat (40) step(0);
    end
    chk("en_off_valids", n_valid - nv0, 0);
    chk("en_off_timeouts", n_to - to0, 0);
    chk("en_off_period", po_period, 50);
    chk("en_off_high", po_high, 10);
    chk("en_off_stable", po_stable, 0);
    pi_en = 1'b1;
    repeat (5) step(0);
    repeat (10) step(1);
    repeat (40) step(0);
    chk("reen_first_rise", n_valid - nv0, 0);
    exp_q.push_back('{50, 10, 1'b1});
    repeat (10) step(1);
    repeat (5) step(0);
    chk("reen_second_rise", n_valid - nv0, 1);
    chk("reen_timeouts", n_to - to0, 0);
    repeat (3) step(0);
    chk("pre_rst_stable", po_stable, 1);
    rst = 1'b1;
    step(0);
    rc = cyc;
    chk("mid_rst_period", po_period, 0);
    chk("mid_rst_high", po_high, 0);
    chk("mid_rst_valid", po_valid, 0);
    chk("mid_rst_timeout", po_timeout, 0);
    chk("mid_rst_stable", po_stable, 0);
    rst = 1'b0;
    to_q.delete();
    repeat (120) step(0);
    chk("rst_to_count", to_q.size(), 1);
    if (to_q.size() >= 1) chk("rst_arm_delay", to_q[0] - rc, 101);
    rst = 1'b1;
    pi_en = 1'b0;
    step(0);
    rst = 1'b0;
    repeat (10) step(1);
    pi_en = 1'b1;
    nv0 = n_valid;
    to0 = n_to;
    repeat (150) step(1);
    chk("held_high_valids", n_valid - nv0, 0);
    chk("held_high_timeouts", n_to - to0, 1);
    repeat (5) step(0);
    repeat (7) step(1);
    repeat (23) step(0);
    chk("late_rise_first", n_valid - nv0, 0);
    exp_q.push_back('{30, 7, 1'b0});
    repeat (7) step(1);
    repeat (5) step(0);
    chk("late_rise_second", n_valid - nv0, 1);
    chk("exp_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
